// File: rtl/o_ru_seq_pkg.sv
// Shared types and constants for the O-RU symbol descriptor sequencer.
package o_ru_seq_pkg;

  localparam int NUM_CH_D = 4;
  localparam int PRB_W_D  = 9;
  localparam int FFT_W_D  = 4;
  localparam int CW_W_D   = 5;
  localparam int FS_W_D   = 8;
  localparam int SLOT_W_D = 8;
  localparam int CH_W_D   = 2;
  localparam int SYM_W    = 4;

  localparam int SYMS_NORM_CP = 14;
  localparam int SYMS_EXT_CP  = 12;
  localparam int SC_PER_PRB   = 12;
  localparam int CW_DEFAULT   = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_EMIT = 3'd2,
    ST_ADV  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef struct packed {
    logic [SLOT_W_D-1:0] slot;
    logic [SYM_W-1:0]    sym_no;
    logic [CH_W_D-1:0]   ch;
    logic [FFT_W_D-1:0]  fft_log2;
    logic [PRB_W_D-1:0]  num_prb;
    logic [2:0]          mu;
    logic [CW_W_D-1:0]   c_width;
    logic [FS_W_D-1:0]   fs_off;
    logic [PRB_W_D+5:0]  n_bytes;
  } desc_t;

endpackage

// File: rtl/o_ru_sym_desc_calc.sv
// IQ byte count for one symbol of one channel: num_prb * 12 sc * 2 (I/Q) * cw / 8.
// A c_width of 0 encodes the 16-bit default.
module o_ru_sym_desc_calc
  import o_ru_seq_pkg::*;
#(
  parameter int PRB_W = 9,
  parameter int CW_W  = 5
) (
  input  logic [PRB_W-1:0] num_prb,
  input  logic [CW_W-1:0]  c_width,
  output logic [PRB_W+5:0] n_bytes
);

  // 12 subcarriers * 2 samples * bits / 8 collapses to a factor of 3 per bit of width.
  localparam int BYTE_MUL = SC_PER_PRB * 2 / 8;

  logic [CW_W:0] cw;

  assign cw      = (c_width == '0) ? (CW_W+1)'(CW_DEFAULT) : {1'b0, c_width};
  assign n_bytes = (PRB_W+6)'(num_prb) * (PRB_W+6)'(BYTE_MUL) * (PRB_W+6)'(cw);

endmodule

// File: rtl/o_ru_sym_desc_seq.sv
// Multi-channel symbol descriptor sequencer: walks slot -> symbol -> channel
// and emits one descriptor per eligible channel per symbol on a valid/ready port.
// Optional build macro O_RU_SYM_DESC_EXT_CP_EN adds cfg_ext_cp (12-symbol slots
// when any enabled channel runs mu=2).
//
// Handshake: desc_valid is high only in EMIT; desc holds steady while
// desc_valid && !desc_ready; a descriptor transfers on the clock edge where
// desc_valid && desc_ready, unless abort is high on that same edge.
module o_ru_sym_desc_seq
  import o_ru_seq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PRB_W  = 9,
  parameter int FFT_W  = 4,
  parameter int CW_W   = 5,
  parameter int FS_W   = 8,
  parameter int SLOT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [SLOT_W-1:0]         cfg_num_slots,
  input  logic [NUM_CH-1:0]         cfg_ch_en,
  input  logic [NUM_CH*PRB_W-1:0]   cfg_num_prb,
  input  logic [NUM_CH*FFT_W-1:0]   cfg_fft_log2,
  input  logic [NUM_CH*3-1:0]       cfg_mu,
  input  logic [NUM_CH*CW_W-1:0]    cfg_c_width,
  input  logic [NUM_CH*FS_W-1:0]    cfg_fs_off,
`ifdef O_RU_SYM_DESC_EXT_CP_EN
  input  logic                      cfg_ext_cp,
`endif
  output logic                      desc_valid,
  input  logic                      desc_ready,
  output logic [$bits(desc_t)-1:0]  desc,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                fsm_state
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e state_q, state_d;

  logic [NUM_CH-1:0]       en_q;
  logic [NUM_CH*PRB_W-1:0] prb_q;
  logic [NUM_CH*FFT_W-1:0] fft_q;
  logic [NUM_CH*3-1:0]     mu_q;
  logic [NUM_CH*CW_W-1:0]  cw_q;
  logic [NUM_CH*FS_W-1:0]  fs_q;
  logic [SLOT_W-1:0]       nslots_q;

  logic [SLOT_W-1:0] slot_q;
  logic [SYM_W-1:0]  sym_q;
  logic [CH_W-1:0]   ch_q;

  logic [NUM_CH-1:0] elig_in, elig_q;
  logic              any_in, has_next;
  logic [CH_W-1:0]   first_in, first_ch, next_ch;
  logic [SYM_W-1:0]  syms_m1;
  logic              last_sym, last_slot;
  logic [PRB_W+5:0]  nb;
  desc_t             d;

  // Eligible channels (enabled and non-empty) and the channel search used by LOAD/ADV.
  always_comb begin
    elig_in  = '0;
    elig_q   = '0;
    any_in   = 1'b0;
    has_next = 1'b0;
    first_in = '0;
    first_ch = '0;
    next_ch  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      elig_in[i] = cfg_ch_en[i] && (cfg_num_prb[i*PRB_W +: PRB_W] != '0);
      elig_q[i]  = en_q[i] && (prb_q[i*PRB_W +: PRB_W] != '0);
      if (elig_in[i]) begin
        any_in   = 1'b1;
        first_in = CH_W'(i);
      end
      if (elig_q[i]) first_ch = CH_W'(i);
      if (elig_q[i] && (i > int'(ch_q))) begin
        has_next = 1'b1;
        next_ch  = CH_W'(i);
      end
    end
  end

`ifdef O_RU_SYM_DESC_EXT_CP_EN
  logic ext_cp_q;
  logic any_mu2;

  // Extended CP shortens the slot only when some enabled channel runs mu=2.
  always_comb begin
    any_mu2 = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en_q[i] && (mu_q[i*3 +: 3] == 3'd2)) any_mu2 = 1'b1;
    end
    syms_m1 = (ext_cp_q && any_mu2) ? SYM_W'(SYMS_EXT_CP - 1) : SYM_W'(SYMS_NORM_CP - 1);
  end

  // Extended-CP flag captured alongside the rest of the run config.
  always_ff @(posedge clk) begin
    if (rst) ext_cp_q <= 1'b0;
    else if (state_q == ST_LOAD) ext_cp_q <= cfg_ext_cp;
  end
`else
  assign syms_m1 = SYM_W'(SYMS_NORM_CP - 1);
`endif

  assign last_sym  = (sym_q == syms_m1);
  assign last_slot = (slot_q == SLOT_W'(nslots_q - 1'b1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition, including start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: state_d = ((cfg_num_slots == '0) || !any_in) ? ST_DONE : ST_EMIT;
      ST_EMIT: if (desc_ready) state_d = ST_ADV;
      ST_ADV:  state_d = (has_next || !last_sym || !last_slot) ? ST_EMIT : ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Shadow config capture in LOAD and slot/symbol/channel walk in ADV.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= '0;
      prb_q    <= '0;
      fft_q    <= '0;
      mu_q     <= '0;
      cw_q     <= '0;
      fs_q     <= '0;
      nslots_q <= '0;
      slot_q   <= '0;
      sym_q    <= '0;
      ch_q     <= '0;
    end else if (state_q == ST_LOAD) begin
      en_q     <= cfg_ch_en;
      prb_q    <= cfg_num_prb;
      fft_q    <= cfg_fft_log2;
      mu_q     <= cfg_mu;
      cw_q     <= cfg_c_width;
      fs_q     <= cfg_fs_off;
      nslots_q <= cfg_num_slots;
      slot_q   <= '0;
      sym_q    <= '0;
      ch_q     <= first_in;
    end else if ((state_q == ST_ADV) && (state_d == ST_EMIT)) begin
      if (has_next) begin
        ch_q <= next_ch;
      end else begin
        ch_q <= first_ch;
        if (last_sym) begin
          sym_q  <= '0;
          slot_q <= slot_q + 1'b1;
        end else begin
          sym_q <= sym_q + 1'b1;
        end
      end
    end
  end

  o_ru_sym_desc_calc #(
    .PRB_W(PRB_W),
    .CW_W (CW_W)
  ) u_calc (
    .num_prb(prb_q[ch_q*PRB_W +: PRB_W]),
    .c_width(cw_q[ch_q*CW_W +: CW_W]),
    .n_bytes(nb)
  );

  // Descriptor assembled from counters and the current channel's shadow config.
  always_comb begin
    d          = '0;
    d.slot     = slot_q;
    d.sym_no   = sym_q;
    d.ch       = ch_q;
    d.fft_log2 = fft_q[ch_q*FFT_W +: FFT_W];
    d.num_prb  = prb_q[ch_q*PRB_W +: PRB_W];
    d.mu       = mu_q[ch_q*3 +: 3];
    d.c_width  = cw_q[ch_q*CW_W +: CW_W];
    d.fs_off   = fs_q[ch_q*FS_W +: FS_W];
    d.n_bytes  = nb;
  end

  assign desc       = d;
  assign desc_valid = (state_q == ST_EMIT);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign fsm_state  = state_q;

endmodule
